// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-port signals of the shared memory arbiter.
// slave: arbiter side; master: requesters and memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and data, one transaction at a time.
// Grant in IDLE, response MEM_LAT+2 cycles later; requesters hold req until gnt (no queueing).
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STREAK_MAX = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [SW-1:0] STREAK_CAP = SW'(STREAK_MAX);
  localparam logic [CW-1:0] LAT_CNT    = CW'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_own_d;
  logic              r_we;
  logic              r_kill;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [SW-1:0]     r_streak;
  logic [CW-1:0]     r_cnt;
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_d_win;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_issue;
  logic              w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    w_issue  = 1'b0;
    w_last   = 1'b0;
    // Data wins ties unless fetch has already been passed over STREAK_MAX times.
    w_d_win  = bus.d_req && !(bus.if_req && (r_streak == STREAK_CAP));
    case (r_state)
      IDLE: begin
        if (!i_rst) begin
          w_d_gnt  = w_d_win;
          w_if_gnt = bus.if_req && !w_d_win;
        end
        if (w_d_gnt || w_if_gnt) w_next = ISSUE;
      end
      ISSUE: begin
        w_issue = 1'b1;
        w_next  = WAIT;
      end
      WAIT: begin
        if (r_cnt == LAT_CNT) begin
          w_last = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_own_d     <= 1'b0;
      r_we        <= 1'b0;
      r_kill      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_streak    <= '0;
      r_cnt       <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_d_gnt) begin
        r_own_d  <= 1'b1;
        r_we     <= bus.d_we;
        r_addr   <= bus.d_addr;
        r_wdata  <= bus.d_wdata;
        r_kill   <= 1'b0;
        r_streak <= bus.if_req ? r_streak + 1'b1 : '0;
      end else if (w_if_gnt) begin
        r_own_d  <= 1'b0;
        r_we     <= 1'b0;
        r_addr   <= bus.if_addr;
        r_wdata  <= '0;
        r_kill   <= bus.if_kill;
        r_streak <= '0;
      end else if ((r_state != IDLE) && !r_own_d && bus.if_kill) begin
        r_kill <= 1'b1;
      end
      if (w_issue)                        r_cnt <= CW'(1);
      else if ((r_state == WAIT) && !w_last) r_cnt <= r_cnt + 1'b1;
      // A kill arriving in the final WAIT cycle still suppresses the response.
      if (w_last) begin
        if (r_own_d) begin
          r_d_rvalid <= 1'b1;
          if (!r_we) r_d_rdata <= bus.mem_rdata;
        end else if (!(r_kill || bus.if_kill)) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_en    = w_issue;
  assign bus.mem_we    = w_issue && r_we;
  assign bus.mem_addr  = w_issue ? r_addr : '0;
  assign bus.mem_wdata = w_issue ? r_wdata : '0;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 memory model, hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STREAK_MAX(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Memory: data for the address strobed at cycle t appears during cycle t+2 only.
  logic          p1_vld, p2_vld;
  logic [AW-1:0] p1_addr, p2_addr;

  function automatic logic [63:0] memval(input logic [63:0] a);
    case (a)
      64'h40:  return 64'hD503201F;
      64'h28:  return 64'h55;
      default: return a ^ 64'hA5A5_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    p1_vld  <= bus.mem_en;
    p1_addr <= bus.mem_addr;
    p2_vld  <= p1_vld;
    p2_addr <= p1_addr;
  end

  assign bus.mem_rdata = (p2_vld === 1'b1) ? memval(p2_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  logic [9:0] exp_d;

  initial begin
    rst         = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = '0;
    bus.if_kill = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    exp_d       = 10'b01_1110_1111;

    // Reset state, gnt suppressed while rst is high
    cyc(); cyc(); look();
    chk("rst_if_gnt", 64'(bus.if_gnt), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_mem_en", 64'(bus.mem_en), 64'h0);
    chk("rst_if_rvalid", 64'(bus.if_rvalid), 64'h0);
    chk("rst_d_rvalid", 64'(bus.d_rvalid), 64'h0);
    chk("rst_if_rdata", bus.if_rdata, 64'h0);
    chk("rst_d_rdata", bus.d_rdata, 64'h0);
    chk("rst_mem_addr", bus.mem_addr, 64'h0);
    cyc(); rst = 1'b0; bus.if_req = 1'b0;

    // T1: single fetch
    cyc(); bus.if_req = 1'b1; bus.if_addr = 64'h40; look();
    chk("t1_if_gnt", 64'(bus.if_gnt), 64'h1);
    chk("t1_d_gnt", 64'(bus.d_gnt), 64'h0);
    chk("t1_busy0", 64'(bus.busy), 64'h0);
    cyc(); bus.if_req = 1'b0; bus.if_addr = '0; look();
    chk("t1_mem_en", 64'(bus.mem_en), 64'h1);
    chk("t1_mem_we", 64'(bus.mem_we), 64'h0);
    chk("t1_mem_addr", bus.mem_addr, 64'h40);
    chk("t1_busy1", 64'(bus.busy), 64'h1);
    cyc(); look();
    chk("t1_busy2", 64'(bus.busy), 64'h1);
    chk("t1_mem_en2", 64'(bus.mem_en), 64'h0);
    chk("t1_mem_addr2", bus.mem_addr, 64'h0);
    cyc(); look();
    chk("t1_busy3", 64'(bus.busy), 64'h1);
    chk("t1_rvalid3", 64'(bus.if_rvalid), 64'h0);
    cyc(); look();
    chk("t1_rvalid4", 64'(bus.if_rvalid), 64'h1);
    chk("t1_rdata4", bus.if_rdata, 64'hD503201F);
    chk("t1_busy4", 64'(bus.busy), 64'h0);
    cyc(); look();
    chk("t1_rvalid5", 64'(bus.if_rvalid), 64'h0);
    chk("t1_rdata_hold", bus.if_rdata, 64'hD503201F);

    // T2: both request, data wins, fetch follows
    cyc(); bus.if_req = 1'b1; bus.if_addr = 64'h80; bus.d_req = 1'b1; bus.d_addr = 64'h200; look();
    chk("t2_d_gnt", 64'(bus.d_gnt), 64'h1);
    chk("t2_if_gnt0", 64'(bus.if_gnt), 64'h0);
    cyc(); bus.d_req = 1'b0; bus.d_addr = '0; look();
    chk("t2_if_gnt1", 64'(bus.if_gnt), 64'h0);
    chk("t2_mem_addr", bus.mem_addr, 64'h200);
    cyc(); cyc(); cyc(); look();
    chk("t2_d_rvalid", 64'(bus.d_rvalid), 64'h1);
    chk("t2_d_rdata", bus.d_rdata, 64'hA5A50200);
    chk("t2_if_gnt4", 64'(bus.if_gnt), 64'h1);
    chk("t2_if_rvalid4", 64'(bus.if_rvalid), 64'h0);
    cyc(); bus.if_req = 1'b0; cyc(); cyc(); cyc(); look();
    chk("t2_if_rvalid8", 64'(bus.if_rvalid), 64'h1);
    chk("t2_if_rdata8", bus.if_rdata, 64'hA5A50080);
    chk("t2_d_rvalid8", 64'(bus.d_rvalid), 64'h0);

    // T3: continuous contention, starvation guard every fifth grant
    cyc(); bus.if_req = 1'b1; bus.if_addr = 64'h80; bus.d_req = 1'b1; bus.d_addr = 64'h208;
    for (int g = 0; g < 10; g++) begin
      look();
      chk("t3_d_gnt", 64'(bus.d_gnt), 64'(exp_d[g]));
      chk("t3_if_gnt", 64'(bus.if_gnt), 64'(!exp_d[g]));
      if (g > 0) chk("t3_prev_rv", 64'(exp_d[g-1] ? bus.d_rvalid : bus.if_rvalid), 64'h1);
      cyc();
      if (g == 9) begin
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
      cyc(); cyc(); cyc();
    end
    look();
    chk("t3_last_rv", 64'(bus.if_rvalid), 64'h1);
    chk("t3_last_rdata", bus.if_rdata, 64'hA5A50080);

    // T4: read 0x55, then a write that must not disturb d_rdata
    cyc(); bus.d_req = 1'b1; bus.d_addr = 64'h28; look();
    chk("t4_rd_gnt", 64'(bus.d_gnt), 64'h1);
    cyc(); bus.d_req = 1'b0; cyc(); cyc(); cyc(); look();
    chk("t4_rd_rdata", bus.d_rdata, 64'h55);
    cyc(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h100; bus.d_wdata = 64'hDEADBEEF; look();
    chk("t4_wr_gnt", 64'(bus.d_gnt), 64'h1);
    cyc(); bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0; look();
    chk("t4_mem_en", 64'(bus.mem_en), 64'h1);
    chk("t4_mem_we", 64'(bus.mem_we), 64'h1);
    chk("t4_mem_wdata", bus.mem_wdata, 64'hDEADBEEF);
    chk("t4_mem_addr", bus.mem_addr, 64'h100);
    cyc(); cyc(); cyc(); look();
    chk("t4_ack", 64'(bus.d_rvalid), 64'h1);
    chk("t4_rdata_kept", bus.d_rdata, 64'h55);

    // T5: killed fetch, data waits behind it, kill during data has no effect
    cyc(); bus.if_req = 1'b1; bus.if_addr = 64'h40; look();
    chk("t5_if_gnt", 64'(bus.if_gnt), 64'h1);
    cyc(); bus.if_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 64'h300; look();
    chk("t5_d_gnt1", 64'(bus.d_gnt), 64'h0);
    cyc(); bus.if_kill = 1'b1;
    cyc(); bus.if_kill = 1'b0; look();
    chk("t5_d_gnt3", 64'(bus.d_gnt), 64'h0);
    cyc(); look();
    chk("t5_no_rvalid", 64'(bus.if_rvalid), 64'h0);
    chk("t5_rdata_kept", bus.if_rdata, 64'hA5A50080);
    chk("t5_d_gnt4", 64'(bus.d_gnt), 64'h1);
    chk("t5_busy4", 64'(bus.busy), 64'h0);
    cyc(); bus.d_req = 1'b0; cyc(); bus.if_kill = 1'b1; cyc(); bus.if_kill = 1'b0; cyc(); look();
    chk("t5_d_rvalid", 64'(bus.d_rvalid), 64'h1);
    chk("t5_d_rdata", bus.d_rdata, 64'hA5A50300);

    // T5b: kill in the rvalid cycle itself is ignored
    cyc(); bus.if_req = 1'b1; bus.if_addr = 64'h40; look();
    chk("t5b_if_gnt", 64'(bus.if_gnt), 64'h1);
    cyc(); bus.if_req = 1'b0; cyc(); cyc(); cyc(); bus.if_kill = 1'b1; look();
    chk("t5b_rvalid", 64'(bus.if_rvalid), 64'h1);
    chk("t5b_rdata", bus.if_rdata, 64'hD503201F);
    cyc(); bus.if_kill = 1'b0;

    // T6: reset mid-fetch
    cyc(); bus.if_req = 1'b1; bus.if_addr = 64'h40; look();
    chk("t6_if_gnt0", 64'(bus.if_gnt), 64'h1);
    cyc(); bus.if_req = 1'b0;
    cyc(); rst = 1'b1; bus.if_req = 1'b1; bus.if_addr = 64'h48; look();
    chk("t6_gnt_in_rst", 64'(bus.if_gnt), 64'h0);
    cyc(); rst = 1'b0; look();
    chk("t6_busy", 64'(bus.busy), 64'h0);
    chk("t6_mem_en", 64'(bus.mem_en), 64'h0);
    chk("t6_rvalid3", 64'(bus.if_rvalid), 64'h0);
    chk("t6_if_rdata", bus.if_rdata, 64'h0);
    chk("t6_d_rdata", bus.d_rdata, 64'h0);
    chk("t6_if_gnt3", 64'(bus.if_gnt), 64'h1);
    cyc(); bus.if_req = 1'b0; look();
    chk("t6_rvalid4", 64'(bus.if_rvalid), 64'h0);
    chk("t6_mem_en4", 64'(bus.mem_en), 64'h1);
    chk("t6_mem_addr4", bus.mem_addr, 64'h48);
    cyc(); cyc(); cyc(); look();
    chk("t6_rvalid7", 64'(bus.if_rvalid), 64'h1);
    chk("t6_rdata7", bus.if_rdata, 64'hA5A50048);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
